// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and arithmetic helpers for the matmul engine
package matmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WB,
        S_DONE
    } state_t;

    typedef struct packed {
        logic sat;
        logic acc;
    } mode_t;

    // Wide enough that N products of two DW-bit signed values never overflow.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Scale, optionally accumulate into the old C value, then clamp; caller keeps the low DW bits.
    function automatic logic signed [63:0] wb_value(
        input logic signed [63:0] acc,
        input logic signed [63:0] c_old,
        input int                 frac,
        input int                 dw,
        input logic               sat,
        input logic               accm
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = acc >>> frac;
        if (accm) begin
            v = v + c_old;
        end
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat) begin
            if (v > hi) begin
                v = hi;
            end else if (v < lo) begin
                v = lo;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one signed multiply-accumulate lane with clear and enable
module mac_lane #(
    parameter int DW   = 16,
    parameter int ACCW = 36
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;

    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matmul_seq_engine.sv
// rtl/matmul_seq_engine.sv - sequential N x N signed matrix multiply with LANES parallel MAC lanes
module matmul_seq_engine
    import matmul_pkg::*;
#(
    parameter int N     = 16,
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int FRAC  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [2*$clog2(N)-1:0]    wr_addr,
    input  logic [DW-1:0]             wr_data,
    input  logic                      start,
    input  logic                      mode_sat,
    input  logic                      mode_acc,
    output logic                      busy,
    output logic                      done,
    input  logic                      rd_en,
    input  logic [2*$clog2(N)-1:0]    rd_addr,
    output logic [DW-1:0]             rd_data,
    output logic                      rd_valid
);

    localparam int ACCW  = acc_width(DW, N);
    localparam int LN    = $clog2(N);
    localparam int AW    = 2 * LN;
    localparam int LB    = $clog2(LANES);
    localparam int LBW   = (LB > 0) ? LB : 1;
    localparam int GPR   = N / LANES;
    localparam int GW    = (GPR > 1) ? $clog2(GPR) : 1;
    localparam int BAW   = AW - LB;
    localparam int DEPTH = N * N / LANES;

    localparam logic [LN-1:0] LAST_IDX = LN'(N - 1);
    localparam logic [GW-1:0] LAST_GRP = GW'(GPR - 1);

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [LN-1:0] i_q, i_d;
    logic [LN-1:0] k_q, k_d;
    logic [GW-1:0] g_q, g_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    // A is a single array broadcast to all lanes; B and C are banked by column mod LANES.
    logic signed [DW-1:0] a_mem [N*N];
    logic signed [DW-1:0] b_mem [LANES][DEPTH];
    logic signed [DW-1:0] c_mem [LANES][DEPTH];

    logic                   wr_ok;
    logic [LBW-1:0]         wr_bank;
    logic [BAW-1:0]         wr_baddr;
    logic [LBW-1:0]         rd_bank;
    logic [BAW-1:0]         rd_baddr;
    logic [BAW-1:0]         b_addr;
    logic [BAW-1:0]         c_addr;
    logic signed [DW-1:0]   a_val;
    logic signed [ACCW-1:0] acc_w   [LANES];
    logic signed [DW-1:0]   wb_word [LANES];
    logic                   lane_en;
    logic                   lane_clr;

    always_comb begin
        wr_ok    = wr_en && (state_q == S_IDLE);
        wr_bank  = LBW'(wr_addr % AW'(LANES));
        wr_baddr = BAW'(wr_addr / AW'(LANES));
        rd_bank  = LBW'(rd_addr % AW'(LANES));
        rd_baddr = BAW'(rd_addr / AW'(LANES));
        b_addr   = BAW'(int'(k_q) * GPR + int'(g_q));
        c_addr   = BAW'(int'(i_q) * GPR + int'(g_q));
        a_val    = a_mem[{i_q, k_q}];
        lane_en  = (state_q == S_MAC);
        lane_clr = !lane_en;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .DW  (DW),
            .ACCW(ACCW)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (lane_clr),
            .en   (lane_en),
            .a    (a_val),
            .b    (b_mem[l][b_addr]),
            .acc  (acc_w[l])
        );
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            wb_word[l] = DW'(wb_value(64'(acc_w[l]), 64'(c_mem[l][c_addr]),
                                      FRAC, DW, mode_q.sat, mode_q.acc));
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        i_d     = i_q;
        k_d     = k_q;
        g_d     = g_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = '{sat: mode_sat, acc: mode_acc};
                    i_d     = '0;
                    k_d     = '0;
                    g_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_IDX) begin
                    k_d     = '0;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_MAC;
                if (g_q == LAST_GRP) begin
                    g_d = '0;
                    if (i_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reads are serviced only while the result array is stable (IDLE or DONE).
    always_comb begin
        rd_valid_d = rd_en && ((state_q == S_IDLE) || (state_q == S_DONE));
        rd_data_d  = rd_data_q;
        if (rd_valid_d) begin
            rd_data_d = c_mem[rd_bank][rd_baddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            i_q        <= '0;
            k_q        <= '0;
            g_q        <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            i_q        <= i_d;
            k_q        <= k_d;
            g_q        <= g_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !wr_sel) begin
            a_mem[wr_addr] <= wr_data;
        end
        if (wr_ok && wr_sel) begin
            b_mem[wr_bank][wr_baddr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_WB) begin
            for (int l = 0; l < LANES; l++) begin
                c_mem[l][c_addr] <= wb_word[l];
            end
        end
    end

    assign busy     = (state_q == S_MAC) || (state_q == S_WB);
    assign done     = (state_q == S_DONE);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_matmul_seq_engine.sv
// tb/tb_matmul_seq_engine.sv - directed self-checking bench for matmul_seq_engine
module tb_matmul_seq_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, wr_sel, start, mode_sat, mode_acc, rd_en;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;
    logic        busy, done, rd_valid;

    logic        f_wr_en, f_wr_sel, f_start, f_rd_en;
    logic [3:0]  f_wr_addr, f_rd_addr;
    logic [15:0] f_wr_data, f_rd_data;
    logic        f_busy, f_done, f_rd_valid;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int cyc;

    logic [15:0] fb [16] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF,
                             16'h0001, 16'hFF00, 16'h00FF, 16'hABCD,
                             16'h0000, 16'h4000, 16'hC000, 16'h0100,
                             16'h5A5A, 16'hA5A5, 16'h0010, 16'hFFFE};

    always #5 clk = ~clk;

    matmul_seq_engine #(.N(16), .DW(16), .LANES(4), .FRAC(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .mode_sat(mode_sat), .mode_acc(mode_acc),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    matmul_seq_engine #(.N(4), .DW(16), .LANES(2), .FRAC(8)) dut_frac (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_sel(f_wr_sel), .wr_addr(f_wr_addr),
        .wr_data(f_wr_data), .start(f_start), .mode_sat(1'b0), .mode_acc(1'b0),
        .busy(f_busy), .done(f_done), .rd_en(f_rd_en), .rd_addr(f_rd_addr),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 8'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic fill(input logic sel, input logic [15:0] d);
        for (int a = 0; a < 256; a++) wr(sel, a, d);
    endtask

    task automatic check_all(input logic [15:0] exp, input string tag);
        for (int a = 0; a < 256; a++) begin
            rd_en = 1'b1; rd_addr = 8'(a);
            @(posedge clk); #1;
            rd_en = 1'b0;
            check({tag, "_valid"}, rd_valid, 1);
            check(tag, rd_data, exp);
        end
    endtask

    // Returns the edge count at which done is seen, counting the start edge as 1.
    task automatic run(input logic sat, input logic acc, output int c);
        mode_sat = sat; mode_acc = acc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0; c = 1;
        while (!done && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic finish_run(input string tag);
        check({tag, "_done_busy"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        {wr_en, wr_sel, start, mode_sat, mode_acc, rd_en} = '0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        {f_wr_en, f_wr_sel, f_start, f_rd_en} = '0;
        f_wr_addr = '0; f_wr_data = '0; f_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_f_busy", f_busy, 0);
        check("rst_f_rd_data", f_rd_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity x ones; last diagonal write shares the cycle with start.
        fill(1'b0, 16'h0000);
        for (int i = 0; i < 15; i++) wr(1'b0, i * 17, 16'h0001);
        fill(1'b1, 16'h0001);
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd255; wr_data = 16'h0001;
        run(1'b0, 1'b0, cyc);
        check("id_done_cycle", cyc, 1089);
        finish_run("id");
        check_all(16'h0001, "id");

        // 2s x 3s, then accumulate a second time.
        fill(1'b0, 16'h0002);
        fill(1'b1, 16'h0003);
        run(1'b0, 1'b0, cyc);
        check("two3_done_cycle", cyc, 1089);
        finish_run("two3");
        check_all(16'h0060, "two3");
        run(1'b0, 1'b1, cyc);
        finish_run("acc");
        check_all(16'h00C0, "acc");

        // Write, start and read while busy must all be ignored.
        mode_sat = 1'b0; mode_acc = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        check("busy_after_start", busy, 1);
        while (!done && cyc < 3000) begin
            if (cyc == 100) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 16'h7FFF;
                start = 1'b1; rd_en = 1'b1; rd_addr = 8'd0;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 101) begin
                wr_en = 1'b0; start = 1'b0; rd_en = 1'b0;
                check("busy_rd_valid", rd_valid, 0);
            end
        end
        check("busy_done_cycle", cyc, 1089);
        start = 1'b1; rd_en = 1'b1; rd_addr = 8'd5;
        @(posedge clk); #1;
        start = 1'b0; rd_en = 1'b0;
        check("done_start_busy", busy, 0);
        check("done_start_done", done, 0);
        check("done_rd_valid", rd_valid, 1);
        check("done_rd_data", rd_data, 16'h0060);
        repeat (3) @(posedge clk);
        #1;
        check("done_start_idle", busy, 0);
        check_all(16'h0060, "busy_ign");

        // Saturation and wrap at the extremes.
        fill(1'b0, 16'h7FFF);
        fill(1'b1, 16'h7FFF);
        run(1'b1, 1'b0, cyc);
        finish_run("satpos");
        check_all(16'h7FFF, "satpos");
        run(1'b0, 1'b0, cyc);
        finish_run("wrap");
        check_all(16'h0010, "wrap");
        fill(1'b0, 16'h8000);
        run(1'b1, 1'b0, cyc);
        finish_run("satneg");
        check_all(16'h8000, "satneg");

        // Reset mid-run, then a fresh run.
        mode_sat = 1'b0; mode_acc = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (499) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_valid", rd_valid, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill(1'b0, 16'h0002);
        fill(1'b1, 16'h0003);
        run(1'b0, 1'b0, cyc);
        check("fresh_done_cycle", cyc, 1089);
        finish_run("fresh");
        check_all(16'h0060, "fresh");

        // FRAC=8 instance: scaled identity reproduces B.
        for (int a = 0; a < 32; a++) begin
            f_wr_en = 1'b1; f_wr_sel = (a >= 16); f_wr_addr = 4'(a % 16);
            f_wr_data = (a >= 16) ? fb[a % 16] : ((a % 5 == 0) ? 16'h0100 : 16'h0000);
            @(posedge clk); #1;
        end
        f_wr_en = 1'b0; f_start = 1'b1;
        @(posedge clk); #1;
        f_start = 1'b0; cyc = 1;
        while (!f_done && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("frac_done_cycle", cyc, 41);
        @(posedge clk); #1;
        for (int a = 0; a < 16; a++) begin
            f_rd_en = 1'b1; f_rd_addr = 4'(a);
            @(posedge clk); #1;
            f_rd_en = 1'b0;
            check("frac_valid", f_rd_valid, 1);
            check("frac_data", f_rd_data, fb[a]);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/matmul_seq_engine.md
# matmul_seq_engine

Parametrised sequential matrix-multiply engine computing C = A × B (optionally C += A × B) for square N×N signed fixed-point matrices using LANES parallel MAC lanes. It replaces the fixed 128×128 flat-bus multiplier: operands are loaded and results read through addressed word ports instead of N²·DW-bit flat buses. It sits behind the accelerator's host/DMA write path and feeds downstream layers through the read port.

## Interface
- N, 16, matrix dimension; power of two, 2..128
- DW, 16, element width, signed two's complement
- LANES, 4, parallel MAC lanes; power of two, divides N
- FRAC, 0, arithmetic right shift applied to each accumulated result (fixed-point scaling)
- ACCW, 2*DW+$clog2(N), accumulator width (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one operand element
- wr_sel  in  1  0 = matrix A, 1 = matrix B
- wr_addr  in  2·log2(N)  row-major index (row·N + col)
- wr_data  in  DW  element value
- start  in  1  start request, sampled only in IDLE
- mode_sat  in  1  1 = saturate results, 0 = wrap (truncate); sampled with start
- mode_acc  in  1  1 = add result into existing C; sampled with start
- busy  out  1  high while computing
- done  out  1  one-cycle completion pulse
- rd_en  in  1  read one C element
- rd_addr  in  2·log2(N)  row-major index into C
- rd_data  out  DW  C element
- rd_valid  out  1  rd_data valid, one cycle after rd_en

## Operation
- States: IDLE → MAC → WB → (MAC | DONE) → IDLE.
- IDLE: writes and reads serviced; start=1 latches mode_sat/mode_acc, clears row i, column group g, and k to 0, enters MAC.
- MAC (N cycles per group): lane l accumulates A[i][k]·B[k][g·LANES+l]; k increments, at k=N−1 go to WB.
- WB (1 cycle): per lane, v = (acc >>> FRAC); if mode_acc, v += sign-extended C[i][g·LANES+l]; then clamp to [−2^(DW−1), 2^(DW−1)−1] if mode_sat, else take low DW bits; write C; clear accumulators. Advance g; on group wrap advance i; after last group of row N−1 go to DONE, else MAC.
- DONE (1 cycle): done=1, then IDLE.
- A stored as single array (A[i][k] broadcast to all lanes); B and C banked by column mod LANES so one k step reads LANES B words and WB writes LANES C words in one cycle.
- Accumulator width ACCW guarantees no internal overflow for any inputs.

## Timing
- Reset: state IDLE, busy=0, done=0, rd_valid=0, rd_data=0, counters 0. A/B/C storage not reset (contents undefined until written).
- start accepted at edge 0 → busy=1 from cycle 1 through cycle G·(N+1), G = N²/LANES; done=1 at cycle G·(N+1)+1 with busy=0.
- start while busy or in DONE: ignored.
- wr_en while not IDLE: dropped. wr_en and start in same IDLE cycle: write committed and visible to the computation.
- rd_en in IDLE/DONE: rd_valid=1 and rd_data next cycle. rd_en while busy: ignored, rd_valid=0.
- rst_n low mid-operation: immediate return to IDLE, busy/done 0; C contents undefined.

## Structure
- Package matmul_pkg: state enum, mode struct {sat, acc}, clamp/shift function, ACCW derivation function.
- Sub-module mac_lane: one signed DW×DW multiply-accumulate with synchronous clear and enable; instantiated LANES times via generate.

## Test plan
- N=16, LANES=4: A = identity, B = all 0x0001, start → done exactly at cycle 1089; every C element reads 0x0001.
- A = all 0x0002, B = all 0x0003, mode_sat=0 → every C = 0x0060 (16·6); repeat with mode_acc=1 → every C = 0x00C0.
- A = all 0x7FFF, B = all 0x7FFF, mode_sat=1 → every C = 0x7FFF; A = all 0x8000, B = all 0x7FFF → 0x8000; mode_sat=0 → low 16 bits of 16·0x3FFF0001 = 0x0010.
- FRAC=8, A = identity scaled 0x0100, B = random → C equals B.
- Start/write/read while busy ignored (C unchanged vs. golden, rd_valid stays 0); second start during DONE ignored.
- rst_n pulsed at cycle 500 of a run → busy=0, done=0 within the reset; fresh run afterwards produces correct results.
